// File: rtl/mac_pkg.sv
// Shared request-path definitions for mem_access_controller and its request arbiter.
package mac_pkg;

  localparam int TAG_W  = 4;
  localparam int ID_W   = 3;
  localparam int LEN_W  = 2;
  localparam int QOS_W  = 4;
  localparam int MAC_AW = 32;

  // Arbitration key is {urgent, qos}; the urgent bit dominates any QoS value.
  localparam int KEY_W = QOS_W + 1;
  localparam int AGE_W = 4;

  typedef struct packed {
    logic [MAC_AW-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [QOS_W-1:0]  qos;
  } mac_req_t;

  function automatic logic [KEY_W-1:0] mkKey(input logic urgent, input logic [QOS_W-1:0] qos);
    return {urgent, qos};
  endfunction

endpackage

// File: rtl/mac_rr_prio_pick.sv
// Combinational NCH-way max-key picker; ties resolve to the first candidate at or after rrPtr_i.
module mac_rr_prio_pick #(
  parameter int NCH = 4,
  parameter int KW  = 5,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0]    valid_i,
  input  logic [NCH*KW-1:0] keys_i,
  input  logic [CW-1:0]     rrPtr_i,
  output logic [NCH-1:0]    grant_o,
  output logic [CW-1:0]     gIdx_o,
  output logic              any_o
);

  logic [KW-1:0] keyArr [NCH];
  logic [KW-1:0] maxKey;
  logic [CW:0]   slot;
  logic [CW-1:0] idx;
  logic          found;

  for (genvar c = 0; c < NCH; c++) begin : g_keys
    assign keyArr[c] = keys_i[c*KW +: KW];
  end

  assign any_o = |valid_i;

  // First pass finds the winning key, second pass walks the ring from rrPtr_i to break ties.
  always_comb begin
    maxKey  = '0;
    grant_o = '0;
    gIdx_o  = '0;
    slot    = '0;
    idx     = '0;
    found   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (valid_i[c] && (keyArr[c] > maxKey)) begin
        maxKey = keyArr[c];
      end
    end
    for (int k = 0; k < NCH; k++) begin
      slot = {1'b0, rrPtr_i} + (CW+1)'(k);
      if (slot >= (CW+1)'(NCH)) begin
        slot = slot - (CW+1)'(NCH);
      end
      idx = slot[CW-1:0];
      if (!found && valid_i[idx] && (keyArr[idx] == maxKey)) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        gIdx_o       = idx;
      end
    end
  end

endmodule

// File: rtl/mac_req_arbiter.sv
// N-channel request arbiter feeding the MAC through a single registered request port.
module mac_req_arbiter
  import mac_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int AW       = 32,
  parameter int AGE_MAX  = 15,
  parameter int AGING_EN = 1,
  localparam int CW      = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         iReq_Valid,
  input  logic [NCH*AW-1:0]      iReq_Addr,
  input  logic [NCH*TAG_W-1:0]   iReq_Tag,
  input  logic [NCH*ID_W-1:0]    iReq_Id,
  input  logic [NCH*LEN_W-1:0]   iReq_Len,
  input  logic [NCH*QOS_W-1:0]   iReq_QoS,
  output logic [NCH-1:0]         oReq_Ready,
  output logic                   oArb_Valid,
  output logic [AW-1:0]          oArb_Addr,
  output logic [TAG_W-1:0]       oArb_Tag,
  output logic [ID_W-1:0]        oArb_Id,
  output logic [LEN_W-1:0]       oArb_Len,
  output logic [QOS_W-1:0]       oArb_QoS,
  output logic [CW-1:0]          oArb_Ch,
  input  logic                   iArb_Ready
);

  logic [AW-1:0]      addrArr [NCH];
  logic [TAG_W-1:0]   tagArr  [NCH];
  logic [ID_W-1:0]    idArr   [NCH];
  logic [LEN_W-1:0]   lenArr  [NCH];
  logic [QOS_W-1:0]   qosArr  [NCH];
  logic [NCH*KEY_W-1:0] keyFlat;

  logic [AGE_W-1:0] age_q [NCH];
  logic [AGE_W-1:0] age_d [NCH];
  logic [CW-1:0]    rrPtr_q, rrPtr_d;

  logic             arbValid_q, arbValid_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [QOS_W-1:0] qos_q, qos_d;
  logic [CW-1:0]    ch_q, ch_d;

  logic           loadEn;
  logic [NCH-1:0] pickValid;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  gIdx;
  logic           anyValid;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign addrArr[c] = iReq_Addr[c*AW +: AW];
    assign tagArr[c]  = iReq_Tag[c*TAG_W +: TAG_W];
    assign idArr[c]   = iReq_Id[c*ID_W +: ID_W];
    assign lenArr[c]  = iReq_Len[c*LEN_W +: LEN_W];
    assign qosArr[c]  = iReq_QoS[c*QOS_W +: QOS_W];
    assign keyFlat[c*KEY_W +: KEY_W] =
      mkKey((AGING_EN != 0) && (age_q[c] >= AGE_W'(AGE_MAX)), qosArr[c]);
  end

  // Reset also masks the grant so no channel sees an accept during the reset cycle.
  assign loadEn    = !reset && (!arbValid_q || iArb_Ready);
  assign pickValid = iReq_Valid & {NCH{loadEn}};

  mac_rr_prio_pick #(
    .NCH (NCH),
    .KW  (KEY_W)
  ) u_pick (
    .valid_i (pickValid),
    .keys_i  (keyFlat),
    .rrPtr_i (rrPtr_q),
    .grant_o (grant),
    .gIdx_o  (gIdx),
    .any_o   (anyValid)
  );

  assign oReq_Ready = grant;

  always_comb begin
    arbValid_d = arbValid_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    id_d       = id_q;
    len_d      = len_q;
    qos_d      = qos_q;
    ch_d       = ch_q;
    rrPtr_d    = rrPtr_q;
    age_d      = age_q;
    if (loadEn) begin
      arbValid_d = anyValid;
      if (anyValid) begin
        addr_d  = addrArr[gIdx];
        tag_d   = tagArr[gIdx];
        id_d    = idArr[gIdx];
        len_d   = lenArr[gIdx];
        qos_d   = qosArr[gIdx];
        ch_d    = gIdx;
        rrPtr_d = (gIdx == CW'(NCH-1)) ? '0 : gIdx + 1'b1;
      end
    end
    // Waiting channels keep aging even while the output register is stalled.
    for (int c = 0; c < NCH; c++) begin
      if ((AGING_EN == 0) || !iReq_Valid[c] || grant[c]) begin
        age_d[c] = '0;
      end else if (age_q[c] != '1) begin
        age_d[c] = age_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arbValid_q <= 1'b0;
      addr_q     <= '0;
      tag_q      <= '0;
      id_q       <= '0;
      len_q      <= '0;
      qos_q      <= '0;
      ch_q       <= '0;
      rrPtr_q    <= '0;
      age_q      <= '{default: '0};
    end else begin
      arbValid_q <= arbValid_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      id_q       <= id_d;
      len_q      <= len_d;
      qos_q      <= qos_d;
      ch_q       <= ch_d;
      rrPtr_q    <= rrPtr_d;
      age_q      <= age_d;
    end
  end

  assign oArb_Valid = arbValid_q;
  assign oArb_Addr  = addr_q;
  assign oArb_Tag   = tag_q;
  assign oArb_Id    = id_q;
  assign oArb_Len   = len_q;
  assign oArb_QoS   = qos_q;
  assign oArb_Ch    = ch_q;

endmodule

// File: tb/tb_mac_req_arbiter.sv
// Directed scoreboard bench for mac_req_arbiter, with a second instance built without aging.
module tb_mac_req_arbiter;
  import mac_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int CW  = 2;

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [TAG_W-1:0] tag;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic [QOS_W-1:0] qos;
    logic [CW-1:0]    ch;
  } out_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       reqValid = '0;
  logic [NCH*AW-1:0]    reqAddr = '0;
  logic [NCH*TAG_W-1:0] reqTag = '0;
  logic [NCH*ID_W-1:0]  reqId = '0;
  logic [NCH*LEN_W-1:0] reqLen = '0;
  logic [NCH*QOS_W-1:0] reqQos = '0;
  logic                 arbReady = 1'b0;

  logic [NCH-1:0]   ready;
  logic             arbValid;
  logic [AW-1:0]    arbAddr;
  logic [TAG_W-1:0] arbTag;
  logic [ID_W-1:0]  arbId;
  logic [LEN_W-1:0] arbLen;
  logic [QOS_W-1:0] arbQoS;
  logic [CW-1:0]    arbCh;

  logic [NCH-1:0]   nReady;
  logic             nValid;
  logic [AW-1:0]    nAddr;
  logic [TAG_W-1:0] nTag;
  logic [ID_W-1:0]  nId;
  logic [LEN_W-1:0] nLen;
  logic [QOS_W-1:0] nQoS;
  logic [CW-1:0]    nCh;

  out_t obsVec, nObsVec;
  assign obsVec  = {arbValid, arbAddr, arbTag, arbId, arbLen, arbQoS, arbCh};
  assign nObsVec = {nValid, nAddr, nTag, nId, nLen, nQoS, nCh};

  out_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   noAgeCh0 = 0;
  out_t held;

  always #5 clk = ~clk;

  mac_req_arbiter #(.NCH(NCH), .AW(AW), .AGE_MAX(15), .AGING_EN(1)) dut (
    .clk(clk), .reset(reset),
    .iReq_Valid(reqValid), .iReq_Addr(reqAddr), .iReq_Tag(reqTag),
    .iReq_Id(reqId), .iReq_Len(reqLen), .iReq_QoS(reqQos),
    .oReq_Ready(ready), .oArb_Valid(arbValid), .oArb_Addr(arbAddr),
    .oArb_Tag(arbTag), .oArb_Id(arbId), .oArb_Len(arbLen),
    .oArb_QoS(arbQoS), .oArb_Ch(arbCh), .iArb_Ready(arbReady)
  );

  mac_req_arbiter #(.NCH(NCH), .AW(AW), .AGE_MAX(15), .AGING_EN(0)) dutNoAge (
    .clk(clk), .reset(reset),
    .iReq_Valid(reqValid), .iReq_Addr(reqAddr), .iReq_Tag(reqTag),
    .iReq_Id(reqId), .iReq_Len(reqLen), .iReq_QoS(reqQos),
    .oReq_Ready(nReady), .oArb_Valid(nValid), .oArb_Addr(nAddr),
    .oArb_Tag(nTag), .oArb_Id(nId), .oArb_Len(nLen),
    .oArb_QoS(nQoS), .oArb_Ch(nCh), .iArb_Ready(arbReady)
  );

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCh(input int c, input logic [AW-1:0] a, input logic [3:0] t,
                       input logic [2:0] i, input logic [1:0] l, input logic [3:0] q);
    reqAddr[c*AW +: AW]       = a;
    reqTag[c*TAG_W +: TAG_W]  = t;
    reqId[c*ID_W +: ID_W]     = i;
    reqLen[c*LEN_W +: LEN_W]  = l;
    reqQos[c*QOS_W +: QOS_W]  = q;
  endtask

  function automatic out_t mkExp(input int c);
    out_t e;
    e.valid = 1'b1;
    e.addr  = reqAddr[c*AW +: AW];
    e.tag   = reqTag[c*TAG_W +: TAG_W];
    e.id    = reqId[c*ID_W +: ID_W];
    e.len   = reqLen[c*LEN_W +: LEN_W];
    e.qos   = reqQos[c*QOS_W +: QOS_W];
    e.ch    = CW'(c);
    return e;
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] v, input logic rdy);
    reqValid = v;
    arbReady = rdy;
  endtask

  // c < 0 means no channel may be accepted this cycle.
  task automatic expectGrant(input string tag, input int c);
    #1;
    if (c < 0) begin
      checkEq(tag, 64'(ready), 64'd0);
    end else begin
      checkEq(tag, 64'(ready), 64'(4'b0001 << c));
      expQ.push_back(mkExp(c));
    end
  endtask

  task automatic checkOutput(input string tag);
    out_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkEq(tag, 64'(obsVec), 64'(e));
    end else begin
      checkEq({tag, "_idle"}, 64'(arbValid), 64'd0);
    end
  endtask

  initial begin
    repeat (2) tick();
    checkEq("rst_out", 64'(obsVec), 64'd0);
    checkEq("rst_ready", 64'(ready), 64'd0);
    checkEq("rst_noage_out", 64'(nObsVec), 64'd0);
    reset = 1'b0;

    // Single channel, one-cycle latency, then idle.
    setCh(2, 32'h2345_F220, 4'hA, 3'b101, 2'b10, 4'b0110);
    applyStimulus(4'b0100, 1'b1);
    expectGrant("single_ready", 2);
    tick(); checkOutput("single_out");
    applyStimulus(4'b0000, 1'b1);
    expectGrant("single_drop", -1);
    tick(); checkOutput("single_after");

    // Higher QoS wins regardless of round-robin position.
    setCh(0, 32'h0000_1000, 4'h1, 3'b000, 2'b00, 4'd3);
    setCh(3, 32'h3000_3000, 4'h3, 3'b011, 2'b01, 4'd9);
    applyStimulus(4'b1001, 1'b1);
    expectGrant("qos_first", 3);
    tick(); checkOutput("qos_first_out");
    applyStimulus(4'b0001, 1'b1);
    expectGrant("qos_second", 0);
    tick(); checkOutput("qos_second_out");
    applyStimulus(4'b0000, 1'b1);
    expectGrant("qos_drop", -1);
    tick(); checkOutput("qos_idle");

    // Backpressure: held request stays stable for 6 cycles, then drains and reloads.
    setCh(1, 32'hB00C_0001, 4'h5, 3'b001, 2'b11, 4'd7);
    held = mkExp(1);
    applyStimulus(4'b0010, 1'b0);
    expectGrant("bp_load", 1);
    tick(); checkOutput("bp_loaded");
    setCh(3, 32'hB00C_0003, 4'h6, 3'b110, 2'b00, 4'd2);
    applyStimulus(4'b1000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expectGrant($sformatf("bp_stall%0d", k), -1);
      checkEq($sformatf("bp_hold%0d", k), 64'(obsVec), 64'(held));
      tick();
    end
    applyStimulus(4'b1000, 1'b1);
    expectGrant("bp_release", 3);
    checkEq("bp_hold_last", 64'(obsVec), 64'(held));
    tick(); checkOutput("bp_next");
    applyStimulus(4'b0000, 1'b1);
    expectGrant("bp_drop", -1);
    tick(); checkOutput("bp_idle");

    // Reset while a request is stalled in the output register.
    setCh(2, 32'hDEAD_0002, 4'h7, 3'b010, 2'b01, 4'd4);
    applyStimulus(4'b0100, 1'b0);
    expectGrant("rstmid_load", 2);
    tick(); checkOutput("rstmid_loaded");
    applyStimulus(4'b0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkEq("rstmid_out", 64'(obsVec), 64'd0);
    checkEq("rstmid_ready", 64'(ready), 64'd0);
    applyStimulus(4'b0000, 1'b1);
    tick(); checkOutput("rstmid_no_issue");

    // Equal QoS: round-robin from pointer 0 with wrap, one grant per cycle.
    for (int c = 0; c < NCH; c++) begin
      setCh(c, 32'h5000_0000 + 32'(c), 4'(c + 8), 3'(c), 2'(c), 4'd5);
    end
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expectGrant($sformatf("rr_ready%0d", i), i % NCH);
      tick(); checkOutput($sformatf("rr_out%0d", i));
    end
    applyStimulus(4'b0000, 1'b1);
    expectGrant("rr_drop", -1);
    tick(); checkOutput("rr_idle");

    // Aging: low-QoS ch0 is promoted after 15 waiting cycles; the no-aging instance never serves it.
    setCh(0, 32'hA000_0000, 4'h0, 3'b000, 2'b00, 4'd0);
    setCh(1, 32'hA000_0001, 4'h1, 3'b001, 2'b01, 4'hF);
    applyStimulus(4'b0011, 1'b1);
    for (int i = 0; i < 100; i++) begin
      expectGrant($sformatf("age_ready%0d", i), ((i % 16) == 15) ? 0 : 1);
      if (nReady[0]) noAgeCh0++;
      tick(); checkOutput($sformatf("age_out%0d", i));
    end
    checkEq("noage_ch0_grants", 64'(noAgeCh0), 64'd0);
    checkEq("noage_out", 64'(nObsVec), 64'(mkExp(1)));
    applyStimulus(4'b0000, 1'b1);
    expectGrant("age_drop", -1);
    tick(); checkOutput("age_idle");

    checkEq("sb_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
